int_ctrl: RTL



---
 rtl/int_pkg.sv | 12 +
 rtl/int_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and fixed source IDs.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam int unsigned TRAP_ID = 0;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module int_prio_enc #(
  parameter int unsigned N = 7,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level sources plus a PC-match trap, a pending register,
// a mask, and a non-nesting IDLE/REQ/SERVICE handshake with the CPU.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned           NUM_SRC   = 6,
  parameter logic [NUM_SRC-1:0]    EDGE_MASK = '0,
  parameter logic [31:0]           TRAP_RST  = 32'h0000419c,
  parameter int unsigned           ID_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [31:0]        pcm,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [31:0]        cfg_wdata,
  input  logic               trap_en,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC:0]   pending
);

  int_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] mask;
  logic [31:0]        trap_addr;
  logic [NUM_SRC:0]   set_vec;
  logic [NUM_SRC:0]   clr_vec;
  logic [ID_W-1:0]    id_d;
  logic [ID_W-1:0]    enc_idx;
  logic               enc_valid;

  always_comb begin
    set_vec          = '0;
    set_vec[TRAP_ID] = trap_en && (pcm == trap_addr);
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      set_vec[k+1] = EDGE_MASK[k] ? (irq_in[k] & ~irq_q[k]) : irq_in[k];
    end
  end

  int_prio_enc #(
    .N (NUM_SRC + 1),
    .W (ID_W)
  ) u_enc (
    .req   (pending & {mask, 1'b1}),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    id_d    = int_id;
    clr_vec = '0;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = REQ;
          id_d    = enc_idx;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
          for (int unsigned i = 0; i <= NUM_SRC; i++) begin
            clr_vec[i] = (int_id == ID_W'(i));
          end
        end
      end
      SERVICE: begin
        if (int_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_req = (state_q == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      int_id    <= '0;
      pending   <= '0;
      irq_q     <= '0;
      mask      <= '1;
      trap_addr <= TRAP_RST;
    end else begin
      state_q <= state_d;
      int_id  <= id_d;
      // Set is OR'd after the clear so a same-cycle event on the acked bit survives.
      pending <= (pending & ~clr_vec) | set_vec;
      irq_q   <= irq_in;
      if (cfg_we) begin
        if (cfg_sel) trap_addr <= cfg_wdata;
        else         mask      <= cfg_wdata[NUM_SRC-1:0];
      end
    end
  end

endmodule
